// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: one output byte per clock through a single xtime-based multiplier pair.
// Define MIXSEQ_INV_EN to add the `inv` port and the InvMixColumns pre-pass.
module mix_columns_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
`ifdef MIXSEQ_INV_EN
    input  logic         inv,
`endif
    input  logic [127:0] state_in,
    output logic         ready,
    output logic         done,
    output logic [127:0] state_out
);

`ifdef MIXSEQ_INV_EN
    typedef enum logic [1:0] {StIdle, StPre, StMix} st_e;
`else
    typedef enum logic [1:0] {StIdle, StMix} st_e;
`endif

    st_e           st_q, st_d;
    logic [127:0]  s_q, s_d;
    logic [127:0]  out_q, out_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          done_q, done_d;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k sits at bits [127-8k -: 8], i.e. a right shift of 8*(15-k).
    function automatic logic [7:0] get_byte(input logic [127:0] v, input logic [3:0] k);
        logic [127:0] t;
        t = v >> {~k, 3'b000};
        return t[7:0];
    endfunction

    // Shared MixColumns datapath for the byte selected by cnt.
    logic [1:0] col, r0, r1, r2, r3;
    logic [7:0] b0, b1, b2, b3, mix_byte;
    logic [6:0] byte_sh;

    always_comb begin
        col      = cnt_q[3:2];
        r0       = cnt_q[1:0];
        r1       = r0 + 2'd1;
        r2       = r0 + 2'd2;
        r3       = r0 + 2'd3;
        b0       = get_byte(s_q, {col, r0});
        b1       = get_byte(s_q, {col, r1});
        b2       = get_byte(s_q, {col, r2});
        b3       = get_byte(s_q, {col, r3});
        mix_byte = xtime(b0) ^ (xtime(b1) ^ b1) ^ b2 ^ b3;
        byte_sh  = {~cnt_q, 3'b000};
    end

`ifdef MIXSEQ_INV_EN
    logic [1:0]  pc_q, pc_d;
    logic [7:0]  a0, a1, a2, a3, u, v;
    logic [6:0]  col_sh;
    logic [31:0] pre_col;

    // Pre-pass turns InvMixColumns into MixColumns: a0^u, a1^v, a2^u, a3^v.
    always_comb begin
        a0      = get_byte(s_q, {pc_q, 2'd0});
        a1      = get_byte(s_q, {pc_q, 2'd1});
        a2      = get_byte(s_q, {pc_q, 2'd2});
        a3      = get_byte(s_q, {pc_q, 2'd3});
        u       = xtime(xtime(a0 ^ a2));
        v       = xtime(xtime(a1 ^ a3));
        pre_col = {a0 ^ u, a1 ^ v, a2 ^ u, a3 ^ v};
        col_sh  = {~pc_q, 5'b00000};
    end
`endif

    always_comb begin
        st_d   = st_q;
        s_d    = s_q;
        out_d  = out_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
`ifdef MIXSEQ_INV_EN
        pc_d   = pc_q;
`endif
        unique case (st_q)
            StIdle: begin
                if (start) begin
                    s_d   = state_in;
                    cnt_d = 4'd0;
`ifdef MIXSEQ_INV_EN
                    pc_d  = 2'd0;
                    st_d  = inv ? StPre : StMix;
`else
                    st_d  = StMix;
`endif
                end
            end
`ifdef MIXSEQ_INV_EN
            StPre: begin
                s_d  = (s_q & ~({96'b0, 32'hffff_ffff} << col_sh)) | ({96'b0, pre_col} << col_sh);
                pc_d = pc_q + 2'd1;
                if (pc_q == 2'd3) begin
                    st_d = StMix;
                end
            end
`endif
            StMix: begin
                out_d = (out_q & ~({120'b0, 8'hff} << byte_sh)) | ({120'b0, mix_byte} << byte_sh);
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    done_d = 1'b1;
                    st_d   = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= StIdle;
            s_q    <= 128'h0;
            out_q  <= 128'h0;
            cnt_q  <= 4'd0;
            done_q <= 1'b0;
`ifdef MIXSEQ_INV_EN
            pc_q   <= 2'd0;
`endif
        end else begin
            st_q   <= st_d;
            s_q    <= s_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
`ifdef MIXSEQ_INV_EN
            pc_q   <= pc_d;
`endif
        end
    end

    assign ready     = (st_q == StIdle);
    assign done      = done_q;
    assign state_out = out_q;

endmodule
